// File: rtl/adder_pkg.sv
// ============================================================================
// adder_pkg : shared types and elaboration helpers for seq_adder
// Revision  : 1.0
// ============================================================================
`default_nettype none

package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int digit_count(input int width, input int digit);
        return width / digit;
    endfunction

    // A single-step configuration still needs a one-bit counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/adder_digit.sv
// ============================================================================
// adder_digit : combinational DIGIT-bit ripple-carry adder
// Revision    : 1.0
// ============================================================================
`default_nettype none

module adder_digit #(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_c_in,
    output logic [DIGIT-1:0] o_sum,
    output logic             o_c_out
);

    logic [DIGIT:0] w_c;

    assign w_c[0] = i_c_in;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
        assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_c_out = w_c[DIGIT];

endmodule

`default_nettype wire

// File: rtl/seq_adder.sv
// ============================================================================
// seq_adder : digit-serial adder/subtractor, LS digit first, valid/ready I/O
// Revision  : 1.0
// ============================================================================
`default_nettype none

module seq_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_c_out,
    output logic             o_ovf,
    output logic             o_zero
);

    localparam int C_N  = digit_count(WIDTH, DIGIT);
    localparam int C_CW = cnt_width(C_N);
    localparam logic [C_CW-1:0] C_LAST = C_CW'(C_N - 1);

    if ((WIDTH % DIGIT) != 0) begin : g_width_check
        $error("seq_adder: WIDTH must be a multiple of DIGIT");
    end

    state_t            r_state;
    state_t            w_next;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_acc;
    logic              r_carry;
    logic [C_CW-1:0]   r_cnt;
    logic [WIDTH-1:0]  r_sum;
    logic              r_c_out;
    logic              r_ovf;
    logic              r_zero;

    logic              w_accept;
    logic              w_last;
    logic [31:0]       w_base;
    logic [DIGIT-1:0]  w_dsum;
    logic              w_dcout;
    logic [WIDTH-1:0]  w_sum_full;

    assign w_accept = i_valid && (r_state == IDLE);
    assign w_last   = (r_state == RUN) && (r_cnt == C_LAST);
    assign w_base   = 32'(r_cnt) * 32'(DIGIT);

    adder_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .i_a     (r_a[w_base +: DIGIT]),
        .i_b     (r_b[w_base +: DIGIT]),
        .i_c_in  (r_carry),
        .o_sum   (w_dsum),
        .o_c_out (w_dcout)
    );

    // Full result as it will look after this step; flags are taken from it
    // so they see the final digit on the last RUN edge.
    always_comb begin
        w_sum_full                   = r_acc;
        w_sum_full[w_base +: DIGIT]  = w_dsum;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_valid) w_next = RUN;
            RUN:     if (r_cnt == C_LAST) w_next = DONE;
            DONE:    if (i_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        o_ready = (r_state == IDLE);
        o_valid = (r_state == DONE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_c_out <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= i_a;
            r_b     <= i_sub ? ~i_b : i_b;
            r_carry <= i_sub;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_acc[w_base +: DIGIT] <= w_dsum;
            r_carry                <= w_dcout;
            r_cnt                  <= r_cnt + 1'b1;
            if (w_last) begin
                r_sum   <= w_sum_full;
                r_c_out <= w_dcout;
                r_ovf   <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                           (w_sum_full[WIDTH-1] != r_a[WIDTH-1]);
                r_zero  <= (w_sum_full == '0);
            end
        end
    end

    assign o_sum   = r_sum;
    assign o_c_out = r_c_out;
    assign o_ovf   = r_ovf;
    assign o_zero  = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_seq_adder.sv
// ============================================================================
// tb_seq_adder : directed + random checks of seq_adder for DIGIT 8/1/4/32
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_seq_adder;

    localparam int W  = 32;
    localparam int NI = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a_i   = '0;
    logic [31:0] b_i   = '0;
    logic        sub_i = 1'b0;

    logic        valid_i [NI];
    logic        ready_i [NI];
    logic        ready_o [NI];
    logic        valid_o [NI];
    logic        cout_o  [NI];
    logic        ovf_o   [NI];
    logic        zero_o  [NI];
    logic [31:0] sum_o   [NI];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        seq_adder #(
            .WIDTH (W),
            .DIGIT ((g == 0) ? 8 : (g == 1) ? 1 : (g == 2) ? 4 : 32)
        ) u_dut (
            .i_clk   (clk),
            .i_rst_n (rst_n),
            .i_valid (valid_i[g]),
            .o_ready (ready_o[g]),
            .i_a     (a_i),
            .i_b     (b_i),
            .i_sub   (sub_i),
            .o_valid (valid_o[g]),
            .i_ready (ready_i[g]),
            .o_sum   (sum_o[g]),
            .o_c_out (cout_o[g]),
            .o_ovf   (ovf_o[g]),
            .o_zero  (zero_o[g])
        );
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full transaction on instance k. hold>0 keeps i_ready low for that
    // many DONE cycles and fires stray requests during RUN and DONE.
    task automatic do_op(input int k, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input int hold);
        logic [32:0] full;
        logic [31:0] es;
        logic        ec;
        logic        eo;
        longint      sr;
        longint      lim;
        int          t;
        int          lat;
        int          exp_lat;

        exp_lat = (k == 0) ? 4 : (k == 1) ? 32 : (k == 2) ? 8 : 1;
        lim     = 64'sd2147483648;
        if (sub) begin
            es = a - b;
            ec = (a >= b);
            sr = longint'($signed(a)) - longint'($signed(b));
        end else begin
            full = {1'b0, a} + {1'b0, b};
            es   = full[31:0];
            ec   = full[32];
            sr   = longint'($signed(a)) + longint'($signed(b));
        end
        eo = (sr >= lim) || (sr < -lim);

        @(negedge clk);
        t = 0;
        while (!ready_o[k] && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("ready_before_accept", 64'(ready_o[k]), 64'd1);

        a_i = a; b_i = b; sub_i = sub; valid_i[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_i = $urandom; b_i = $urandom; sub_i = 1'($urandom_range(0, 1));
        valid_i[k] = (hold > 0);

        lat = 0;
        while (!valid_o[k] && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            valid_i[k] = 1'b0;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        check("ready_in_done", 64'(ready_o[k]), 64'd0);
        check("sum", 64'(sum_o[k]), 64'(es));
        check("c_out", 64'(cout_o[k]), 64'(ec));
        check("ovf", 64'(ovf_o[k]), 64'(eo));
        check("zero", 64'(zero_o[k]), 64'(es == 32'd0));

        for (int i = 0; i < hold; i++) begin
            valid_i[k] = i[0];
            @(posedge clk);
            @(negedge clk);
            check("bp_valid_hold", 64'(valid_o[k]), 64'd1);
            check("bp_ready_low", 64'(ready_o[k]), 64'd0);
            check("bp_sum_hold", 64'(sum_o[k]), 64'(es));
        end

        valid_i[k] = 1'b0;
        ready_i[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ready_i[k] = 1'b0;
        check("ready_after_done", 64'(ready_o[k]), 64'd1);
        check("valid_after_done", 64'(valid_o[k]), 64'd0);
        check("sum_kept_in_idle", 64'(sum_o[k]), 64'(es));
        if (hold > 0) begin
            @(negedge clk);
            check("stray_req_ignored", 64'(valid_o[k] | !ready_o[k]), 64'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        int          nvec;

        for (int i = 0; i < NI; i++) begin
            valid_i[i] = 1'b0;
            ready_i[i] = 1'b0;
        end

        repeat (3) @(negedge clk);
        check("rst_ready", 64'(ready_o[0]), 64'd1);
        check("rst_valid", 64'(valid_o[0]), 64'd0);
        check("rst_sum", 64'(sum_o[0]), 64'd0);
        check("rst_flags", 64'({cout_o[0], ovf_o[0], zero_o[0]}), 64'd0);
        rst_n = 1'b1;

        do_op(0, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 0);
        do_op(0, 32'h8000_0000, 32'h0000_0001, 1'b1, 0);
        do_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
        do_op(0, 32'h0000_0003, 32'h0000_0005, 1'b1, 0);
        do_op(0, 32'hDEAD_BEEF, 32'h0101_0101, 1'b0, 5);

        // Abort in the second RUN cycle; previous result is non-zero.
        @(negedge clk);
        a_i = 32'h5; b_i = 32'h6; sub_i = 1'b0; valid_i[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_i[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_ready", 64'(ready_o[0]), 64'd1);
        check("abort_valid", 64'(valid_o[0]), 64'd0);
        check("abort_sum", 64'(sum_o[0]), 64'd0);
        check("abort_flags", 64'({cout_o[0], ovf_o[0], zero_o[0]}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_no_valid", 64'(valid_o[0]), 64'd0);
        end
        do_op(0, 32'h1234_5678, 32'h1111_1111, 1'b0, 0);

        for (int k = 0; k < NI; k++) begin
            nvec = (k == 0) ? 200 : 1000;
            for (int v = 0; v < nvec; v++) begin
                ra = $urandom;
                rb = $urandom;
                rs = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 7))
                    0: rb = ra;
                    1: ra = 32'h8000_0000;
                    2: rb = 32'hFFFF_FFFF;
                    3: rb = 32'h7FFF_FFFF;
                    default: ;
                endcase
                do_op(k, ra, rb, rs, 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_adder.md
# seq_adder

Parametrised multi-cycle adder/subtractor that processes a WIDTH-bit operation DIGIT bits per clock, least-significant digit first. It uses a valid/ready handshake on both input and output. It produces sum, carry-out, signed-overflow and zero flags, and serves as the area-lean arithmetic unit for non-critical datapaths: address stepping, counters and multi-cycle ALU ops. Throughput trades against area through DIGIT.

## Interface
- WIDTH, 32, operand and result width in bits.
- DIGIT, 8, bits processed per cycle. WIDTH % DIGIT == 0 is required; DIGIT == WIDTH is legal.
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_valid  input  1  operation request.
- o_ready  output  1  unit can accept a request.
- i_a  input  WIDTH  operand A.
- i_b  input  WIDTH  operand B.
- i_sub  input  1  0 computes A+B; 1 computes A-B.
- o_valid  output  1  result available.
- i_ready  input  1  downstream accepts the result.
- o_sum  output  WIDTH  result, modulo 2^WIDTH.
- o_c_out  output  1  carry out of the MSB. For subtract, 1 means no borrow.
- o_ovf  output  1  two's-complement overflow.
- o_zero  output  1  o_sum == 0.

## Operation
- N = WIDTH/DIGIT digit steps. Digit counter width is $clog2(N) with a minimum of 1.
- States:
  - IDLE: o_ready=1, o_valid=0.
  - RUN: o_ready=0, o_valid=0.
  - DONE: o_ready=0, o_valid=1.
- IDLE → RUN when i_valid && o_ready. On that edge the unit latches:
  - A.
  - B_eff = i_sub ? ~i_b : i_b.
  - carry = i_sub.
  - counter = 0.
  - A copy of i_sub.
- RUN, every cycle:
  - Digit k = counter is added: A[k], B_eff[k] and carry.
  - The result digit is written to sum[k]; the carry register takes the digit carry-out.
  - Counter increments.
  - On the step where counter == N-1, go to DONE.
- Flag update on the final RUN edge:
  - o_c_out = final carry.
  - o_ovf = (A[MSB] == B_eff[MSB]) && (sum[MSB] != A[MSB]).
  - o_zero = (full sum == 0).
- DONE → IDLE when i_ready. DONE holds indefinitely while i_ready=0.
- i_valid is ignored outside IDLE. Input operands need to be stable only in the handshake cycle.
- o_sum and the flags are registered. They stay stable throughout DONE and keep their last value in IDLE until the final RUN edge of the next operation.
- The upper WIDTH-DIGIT bits of o_sum are undefined-but-stable during RUN. Consumers sample only when o_valid=1.

## Timing
- Reset (asynchronous, immediate on i_rst_n low):
  - State → IDLE.
  - o_ready=1.
  - o_valid=0.
  - o_sum=0, o_c_out=0, o_ovf=0, o_zero=0.
  - Counter=0, carry=0.
- Reset during RUN or DONE aborts the operation. No o_valid pulse is produced for it.
- Latency: a request accepted at edge T yields o_valid=1 after edge T+N. N=1 when DIGIT==WIDTH.
- Throughput: at most one operation per N+2 cycles when i_ready is held at 1 (accept, N steps, one DONE cycle). o_ready is never asserted in the same cycle as o_valid.
- No combinational path exists from any input to any output. o_ready and o_valid decode from state registers only.

## Structure
- Shared package adder_pkg holds:
  - The state enum typedef: IDLE, RUN, DONE.
  - A localparam function for digit count, used for elaboration checks.
- Sub-module adder_digit: combinational, DIGIT-bit ripple-carry adder.
  - Inputs: a[DIGIT], b[DIGIT], c_in.
  - Outputs: sum[DIGIT], c_out.
  - Instantiated once. Digit selection is by indexed part-select on the counter.
- Elaboration-time assertion that WIDTH % DIGIT == 0.

## Test plan
All vectors use WIDTH=32, DIGIT=8 unless stated.

- Add 0x0000_0001 + 0xFFFF_FFFF → o_sum=0, o_c_out=1, o_zero=1, o_ovf=0. o_valid rises 4 cycles after the accept edge.
- Sub 0x8000_0000 − 0x0000_0001 → o_sum=0x7FFF_FFFF, o_c_out=1, o_ovf=1, o_zero=0.
- Add 0x7FFF_FFFF + 0x0000_0001 → o_sum=0x8000_0000, o_ovf=1, o_c_out=0. Sub 3 − 5 → o_sum=0xFFFF_FFFE, o_c_out=0, o_ovf=0.
- Backpressure: hold i_ready=0 for 5 cycles in DONE, with i_valid pulsed during RUN and DONE.
  - o_valid and the result hold.
  - o_ready stays 0.
  - The pulsed requests are ignored.
  - After i_ready=1, o_ready=1 on the next cycle.
- Drive i_rst_n low in the 2nd RUN cycle.
  - o_ready=1 immediately, o_valid never asserts, and all outputs read 0.
  - After release, 0x1234_5678 + 0x1111_1111 → 0x2345_6789.
- Parameter sweep DIGIT ∈ {1, 4, 32} with 1000 random add/sub vectors each.
  - Results and flags match the reference model.
  - Latency equals WIDTH/DIGIT.
